// File: rtl/move_inverse_stack.sv
// move_inverse_stack
//   Records the moves applied to the cube in a ring-buffer history. On request
//   it plays back the inverse of the most recent move (pop), or of every
//   recorded move, newest first (unwind).
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   clear               synchronous flush of the history and any playback
//   push_valid/face/rot move to record; push_ready is high only when idle
//   pop_req, unwind_req single-cycle undo requests
//   out_valid/face/rot  inverse move offered to the move engine
//   out_ready           move engine accepts the offered move
//   depth, full, empty  occupancy of the history
//   bad_push            one-cycle pulse after an illegal push was rejected
module move_inverse_stack #(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push_valid,
   input  logic [2:0]               push_face,
   input  logic [2:0]               push_rot,
   output logic                     push_ready,
   input  logic                     pop_req,
   input  logic                     unwind_req,
   output logic                     out_valid,
   output logic [2:0]               out_face,
   output logic [2:0]               out_rot,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     full,
   output logic                     empty,
   output logic                     bad_push
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam logic [AW-1:0] ONE_A    = AW'(1);
   localparam logic [AW-1:0] TWO_A    = AW'(2);
   localparam logic [DW-1:0] ONE_D    = DW'(1);
   localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2
   } state_t;

   state_t          state_r;
   logic [AW-1:0]   top_r;
   logic [DW-1:0]   depth_r;
   logic            unwind_r;
   logic            push_ready_r;
   logic            out_valid_r;
   logic [2:0]      out_face_r;
   logic [2:0]      out_rot_r;
   logic            full_r;
   logic            empty_r;
   logic            bad_push_r;
   logic [5:0]      mem_r [DEPTH];
   logic [5:0]      rd_data_r;
   logic [AW-1:0]   rd_addr_s;
   logic            push_legal_s;
   logic            push_store_s;

   // Inverse quarter-turn count: CW and CCW swap, a half turn is its own inverse.
   function automatic logic [2:0] inv_rot(input logic [2:0] rot);
      case (rot)
         3'd1:    inv_rot = 3'd3;
         3'd3:    inv_rot = 3'd1;
         default: inv_rot = rot;
      endcase
   endfunction

   assign push_legal_s = (push_face <= 3'd5) && (push_rot != 3'd0);
   assign push_store_s = !rst && !clear && (state_r == IDLE) && push_valid && push_legal_s;

   // Read address: in EMIT the entry below the one on display is prefetched so
   // that it is ready when an unwind continues through FETCH.
   always_comb begin
      if (state_r == EMIT) begin
         rd_addr_s = top_r - TWO_A;
      end else begin
         rd_addr_s = top_r - ONE_A;
      end
   end

   // History RAM with synchronous read; contents need no reset.
   always_ff @(posedge clk) begin
      if (push_store_s) begin
         mem_r[top_r] <= {push_face, push_rot};
      end
      rd_data_r <= mem_r[rd_addr_s];
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_r      <= IDLE;
         top_r        <= '0;
         depth_r      <= '0;
         unwind_r     <= 1'b0;
         push_ready_r <= 1'b1;
         out_valid_r  <= 1'b0;
         out_face_r   <= 3'd0;
         out_rot_r    <= 3'd0;
         full_r       <= 1'b0;
         empty_r      <= 1'b1;
         bad_push_r   <= 1'b0;
      end else begin
         bad_push_r <= 1'b0;
         case (state_r)
            IDLE: begin
               // A push wins over pop/unwind in the same cycle; the request is dropped.
               if (push_valid) begin
                  if (push_legal_s) begin
                     // When full, top already points at the oldest entry, so
                     // writing there overwrites it and depth stays saturated.
                     top_r <= top_r + ONE_A;
                     if (depth_r != FULL_CNT) begin
                        depth_r <= depth_r + ONE_D;
                        full_r  <= (depth_r == (FULL_CNT - ONE_D));
                        empty_r <= 1'b0;
                     end
                  end else begin
                     bad_push_r <= 1'b1;
                  end
               end else if ((pop_req || unwind_req) && (depth_r != '0)) begin
                  // RAM read at top-1 is issued this cycle by rd_addr_s.
                  unwind_r     <= unwind_req;
                  state_r      <= FETCH;
                  push_ready_r <= 1'b0;
               end
            end
            FETCH: begin
               state_r     <= EMIT;
               out_valid_r <= 1'b1;
               out_face_r  <= rd_data_r[5:3];
               out_rot_r   <= inv_rot(rd_data_r[2:0]);
            end
            EMIT: begin
               if (out_ready) begin
                  top_r       <= top_r - ONE_A;
                  depth_r     <= depth_r - ONE_D;
                  full_r      <= 1'b0;
                  empty_r     <= (depth_r == ONE_D);
                  out_valid_r <= 1'b0;
                  out_face_r  <= 3'd0;
                  out_rot_r   <= 3'd0;
                  if (unwind_r && (depth_r != ONE_D)) begin
                     state_r <= FETCH;
                  end else begin
                     state_r      <= IDLE;
                     unwind_r     <= 1'b0;
                     push_ready_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r      <= IDLE;
               unwind_r     <= 1'b0;
               push_ready_r <= 1'b1;
               out_valid_r  <= 1'b0;
               out_face_r   <= 3'd0;
               out_rot_r    <= 3'd0;
            end
         endcase
      end
   end

   assign push_ready = push_ready_r;
   assign out_valid  = out_valid_r;
   assign out_face   = out_face_r;
   assign out_rot    = out_rot_r;
   assign depth      = depth_r;
   assign full       = full_r;
   assign empty      = empty_r;
   assign bad_push   = bad_push_r;

endmodule

// File: tb/tb_move_inverse_stack.sv
module tb_move_inverse_stack;

   localparam int DEPTH = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       push_valid = 1'b0;
   logic [2:0] push_face = 3'd0;
   logic [2:0] push_rot = 3'd0;
   logic       push_ready;
   logic       pop_req = 1'b0;
   logic       unwind_req = 1'b0;
   logic       out_valid;
   logic [2:0] out_face;
   logic [2:0] out_rot;
   logic       out_ready = 1'b1;
   logic [6:0] depth;
   logic       full;
   logic       empty;
   logic       bad_push;

   int n_cmp = 0;
   int n_fail = 0;
   int n_out = 0;
   logic [5:0] exp_q[$];
   logic [5:0] mstack[$];

   move_inverse_stack #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .push_valid(push_valid), .push_face(push_face), .push_rot(push_rot),
      .push_ready(push_ready), .pop_req(pop_req), .unwind_req(unwind_req),
      .out_valid(out_valid), .out_face(out_face), .out_rot(out_rot),
      .out_ready(out_ready), .depth(depth), .full(full), .empty(empty),
      .bad_push(bad_push)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model of the history: legal pushes, ring overwrite when full.
   task automatic do_push(input logic [2:0] f, input logic [2:0] r);
      push_valid = 1'b1;
      push_face  = f;
      push_rot   = r;
      tick();
      push_valid = 1'b0;
      if (f <= 3'd5 && r != 3'd0) begin
         if (mstack.size() == DEPTH) mstack.delete(0);
         mstack.push_back({f, r});
      end
   endtask

   // Newest recorded move becomes one expected inverse output.
   task automatic model_pop();
      logic [5:0] e;
      logic [2:0] ir;
      e  = mstack.pop_back();
      ir = 3'd4 - e[2:0];
      exp_q.push_back({e[5:3], ir});
   endtask

   task automatic req_pop(input bit unw);
      if (unw) begin
         while (mstack.size() > 0) model_pop();
      end else if (mstack.size() > 0) begin
         model_pop();
      end
      pop_req    = !unw;
      unwind_req = unw;
      tick();
      pop_req    = 1'b0;
      unwind_req = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (push_ready) break;
         tick();
      end
      check(name, push_ready, 1);
   endtask

   task automatic wait_outs(input string name, input int target, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (n_out >= target) break;
         tick();
      end
      check(name, (n_out >= target) ? 1 : 0, 1);
   endtask

   // Monitor: every handshake pops one expected move from the scoreboard.
   always @(negedge clk) begin : monitor
      logic [5:0] e;
      if (!rst) begin
         if (out_valid && out_ready) begin
            n_out++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_out: got face=%0d rot=%0d with nothing expected", out_face, out_rot);
            end else begin
               e = exp_q.pop_front();
               if ({out_face, out_rot} !== e) begin
                  n_fail++;
                  $display("FAIL out_move: got face=%0d rot=%0d expected face=%0d rot=%0d",
                           out_face, out_rot, e[5:3], e[2:0]);
               end
            end
         end else if (!out_valid) begin
            n_cmp++;
            if (out_face != 3'd0 || out_rot != 3'd0) begin
               n_fail++;
               $display("FAIL idle_out_zero: got face=%0d rot=%0d expected 0 0", out_face, out_rot);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_depth", depth, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_push_ready", push_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_bad_push", bad_push, 0);

      // Two pushes, two pops with latency check
      do_push(3'd2, 3'd1);
      do_push(3'd4, 3'd2);
      check("depth_after_2", depth, 2);
      req_pop(1'b0);
      check("pop_lat1_valid", out_valid, 0);
      tick();
      check("pop_lat2_valid", out_valid, 1);
      check("pop1_face", out_face, 4);
      check("pop1_rot", out_rot, 2);
      tick();
      wait_idle("pop1_idle", 20);
      check("depth_after_pop1", depth, 1);
      req_pop(1'b0);
      tick();
      check("pop2_face", out_face, 2);
      check("pop2_rot", out_rot, 3);
      tick();
      wait_idle("pop2_idle", 20);
      check("depth_after_pop2", depth, 0);
      check("empty_after_pop2", empty, 1);

      // 65 pushes overflow the ring, then unwind all 64
      for (int i = 0; i < 65; i++) do_push(3'(i % 6), 3'd1);
      check("ring_depth", depth, 64);
      check("ring_full", full, 1);
      base = n_out;
      req_pop(1'b1);
      tick();
      wait_idle("unwind_idle", 400);
      check("unwind_count", n_out - base, 64);
      check("unwind_empty", empty, 1);
      check("unwind_depth", depth, 0);

      // Pop on empty, illegal pushes
      req_pop(1'b0);
      for (int i = 0; i < 3; i++) begin
         check("empty_pop_valid", out_valid, 0);
         tick();
      end
      do_push(3'd6, 3'd1);
      check("bad_face_pulse", bad_push, 1);
      tick();
      check("bad_face_pulse_end", bad_push, 0);
      check("bad_face_depth", depth, 0);
      do_push(3'd3, 3'd0);
      check("bad_rot_pulse", bad_push, 1);
      tick();
      check("bad_rot_pulse_end", bad_push, 0);
      check("bad_rot_depth", depth, 0);

      // Backpressure in EMIT
      do_push(3'd1, 3'd1);
      do_push(3'd5, 3'd3);
      out_ready = 1'b0;
      req_pop(1'b0);
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_face", out_face, 5);
      check("bp_rot", out_rot, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_face", out_face, 5);
         check("bp_hold_rot", out_rot, 1);
         check("bp_hold_depth", depth, 2);
      end
      out_ready = 1'b1;
      tick();
      check("bp_depth_after", depth, 1);
      check("bp_valid_after", out_valid, 0);
      wait_idle("bp_idle", 20);

      // Clear mid-unwind at depth 10
      for (int i = 0; i < 9; i++) do_push(3'(i % 6), 3'd2);
      check("clr_depth10", depth, 10);
      for (int k = 0; k < 3; k++) model_pop();
      base = n_out;
      unwind_req = 1'b1;
      tick();
      unwind_req = 1'b0;
      wait_outs("clr_wait_outs", base + 3, 50);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mstack.delete();
      check("clr_valid", out_valid, 0);
      check("clr_depth", depth, 0);
      check("clr_idle", push_ready, 1);
      check("clr_empty", empty, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("clr_no_out", out_valid, 0);
      end
      check("clr_queue_drained", exp_q.size(), 0);

      // Reset mid-unwind at depth 10
      for (int i = 0; i < 10; i++) do_push(3'((i + 2) % 6), 3'd3);
      check("rst_mid_depth10", depth, 10);
      for (int k = 0; k < 2; k++) model_pop();
      base = n_out;
      unwind_req = 1'b1;
      tick();
      unwind_req = 1'b0;
      wait_outs("rst_wait_outs", base + 2, 50);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mstack.delete();
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_depth", depth, 0);
      check("rst_mid_idle", push_ready, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rst_mid_no_out", out_valid, 0);
      end
      check("rst_queue_drained", exp_q.size(), 0);

      // Push and pop in the same IDLE cycle: push wins
      do_push(3'd0, 3'd1);
      pop_req = 1'b1;
      do_push(3'd3, 3'd2);
      pop_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("pp_no_out", out_valid, 0);
         tick();
      end
      check("pp_depth", depth, 2);
      req_pop(1'b0);
      tick();
      check("pp_pop_face", out_face, 3);
      check("pp_pop_rot", out_rot, 2);
      tick();
      wait_idle("pp_idle", 20);
      check("pp_depth_after", depth, 1);
      check("final_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
